// File: rtl/tile_loop_gen_pkg.sv
// Shared definitions for the tile loop generator: FSM encoding and the
// default tile geometry used by the layer controller.
package tile_loop_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tile_state_e;

  localparam int DEF_CH         = 4;
  localparam int DEF_ROW        = 8;
  localparam int DEF_COL        = 8;
  localparam int DEF_ROW_STRIDE = 8;
  localparam int DEF_CH_STRIDE  = 64;

endpackage

// File: rtl/loop_dim_cnt.sv
// One loop dimension: counts 0..MAX on inc, wraps to 0 after MAX.
// wrap is the carry into the next-outer dimension (inc while at MAX).
module loop_dim_cnt #(
  parameter int W   = 16,
  parameter int MAX = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max,
  output logic         wrap
);

  assign at_max = (cnt == W'(MAX));
  assign wrap   = inc & at_max;

  // Index register: clear on a new walk, step or wrap on inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= at_max ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/tile_loop_gen.sv
// Walks one feature-map tile in channel/row/column order and emits one
// coordinate plus linear buffer address per accepted beat. Addresses are
// tracked incrementally (channel start, row start, current) so no multiplier
// is needed.
module tile_loop_gen
  import tile_loop_gen_pkg::*;
#(
  parameter int CW         = 16,
  parameter int AW         = 16,
  parameter int CH         = DEF_CH,
  parameter int ROW        = DEF_ROW,
  parameter int COL        = DEF_COL,
  parameter int ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int CH_STRIDE  = DEF_CH_STRIDE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] ROW_STEP = AW'(ROW_STRIDE);
  localparam logic [AW-1:0] CH_STEP  = AW'(CH_STRIDE);

  tile_state_e   state_q, state_d;
  logic          accept, xfer;
  logic          col_max, row_max, ch_max;
  logic          col_wrap, row_wrap, ch_wrap;
  logic [AW-1:0] ch_base_q, row_base_q, addr_q;

  assign accept    = (state_q == ST_IDLE) & start;
  assign out_valid = (state_q == ST_RUN);
  assign xfer      = out_valid & out_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_addr  = addr_q;
  assign out_last  = out_valid & ch_max & row_max & col_max;

  // Counters chained inner to outer: column carry steps the row, row carry
  // steps the channel; the channel carry marks the final beat.
  loop_dim_cnt #(.W(CW), .MAX(COL-1)) u_col (
    .clk(clk), .rst(rst), .clr(accept), .inc(xfer),
    .cnt(out_col), .at_max(col_max), .wrap(col_wrap)
  );
  loop_dim_cnt #(.W(CW), .MAX(ROW-1)) u_row (
    .clk(clk), .rst(rst), .clr(accept), .inc(col_wrap),
    .cnt(out_row), .at_max(row_max), .wrap(row_wrap)
  );
  loop_dim_cnt #(.W(CW), .MAX(CH-1)) u_ch (
    .clk(clk), .rst(rst), .clr(accept), .inc(row_wrap),
    .cnt(out_ch), .at_max(ch_max), .wrap(ch_wrap)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: start only counts in IDLE; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)   state_d = ST_RUN;
      ST_RUN:  if (ch_wrap) state_d = ST_DONE;
      ST_DONE:              state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Address tracking: +1 per column, jump to next row/channel start on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_base_q  <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else if (accept) begin
      ch_base_q  <= base_addr;
      row_base_q <= base_addr;
      addr_q     <= base_addr;
    end else if (row_wrap) begin
      ch_base_q  <= ch_base_q + CH_STEP;
      row_base_q <= ch_base_q + CH_STEP;
      addr_q     <= ch_base_q + CH_STEP;
    end else if (col_wrap) begin
      row_base_q <= row_base_q + ROW_STEP;
      addr_q     <= row_base_q + ROW_STEP;
    end else if (xfer) begin
      addr_q     <= addr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_loop_gen.sv
// Bench for tile_loop_gen: three instances cover the basic geometry, the
// degenerate 1x1x1 tile and the 1x1x4 address-wrap tile. Expected beats come
// from plain nested loops over the tile coordinates.
module tb_tile_loop_gen;

  logic        clk = 0;
  logic        rst = 1;
  logic        st    [3];
  logic [15:0] bs    [3];
  logic        rdy   [3];
  logic        ov    [3];
  logic [15:0] och   [3];
  logic [15:0] orow  [3];
  logic [15:0] ocol  [3];
  logic [15:0] oaddr [3];
  logic        olast [3];
  logic        obusy [3];
  logic        odone [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          ch;
    int          row;
    int          col;
    logic [15:0] addr;
    bit          last;
  } beat_t;

  always #5 clk = ~clk;

  tile_loop_gen #(.CW(16), .AW(16), .CH(2), .ROW(2), .COL(3),
                  .ROW_STRIDE(4), .CH_STRIDE(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .base_addr(bs[0]),
    .out_valid(ov[0]), .out_ready(rdy[0]), .out_ch(och[0]), .out_row(orow[0]),
    .out_col(ocol[0]), .out_addr(oaddr[0]), .out_last(olast[0]),
    .busy(obusy[0]), .done(odone[0])
  );
  tile_loop_gen #(.CW(16), .AW(16), .CH(1), .ROW(1), .COL(1),
                  .ROW_STRIDE(1), .CH_STRIDE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .base_addr(bs[1]),
    .out_valid(ov[1]), .out_ready(rdy[1]), .out_ch(och[1]), .out_row(orow[1]),
    .out_col(ocol[1]), .out_addr(oaddr[1]), .out_last(olast[1]),
    .busy(obusy[1]), .done(odone[1])
  );
  tile_loop_gen #(.CW(16), .AW(16), .CH(1), .ROW(1), .COL(4),
                  .ROW_STRIDE(4), .CH_STRIDE(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(st[2]), .base_addr(bs[2]),
    .out_valid(ov[2]), .out_ready(rdy[2]), .out_ch(och[2]), .out_row(orow[2]),
    .out_col(ocol[2]), .out_addr(oaddr[2]), .out_last(olast[2]),
    .busy(obusy[2]), .done(odone[2])
  );

  function automatic int p_ch(int k);  return (k == 0) ? 2 : 1; endfunction
  function automatic int p_row(int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int p_col(int k);
    return (k == 0) ? 3 : (k == 1) ? 1 : 4;
  endfunction
  function automatic int p_rs(int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 4;
  endfunction
  function automatic int p_chs(int k);
    return (k == 0) ? 16 : (k == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, "_valid"}, 32'(ov[k]), 0);
    chk({tag, "_busy"},  32'(obusy[k]), 0);
    chk({tag, "_done"},  32'(odone[k]), 0);
  endtask

  // One tile walk on instance k. mode: 0 ready high, 1 ready 1,0,0 pattern,
  // 2 random ready. restart_at: beat index where start is re-pulsed while
  // busy. rst_at: beat index where reset is asserted (walk abandoned).
  task automatic walk(input int k, input logic [15:0] b, input int mode,
                      input int restart_at, input int rst_at, input bit start_on_done);
    beat_t q[$];
    beat_t e;
    int    idx = 0;
    int    cyc = 0;
    bit    r;
    for (int c = 0; c < p_ch(k); c++)
      for (int rw = 0; rw < p_row(k); rw++)
        for (int cl = 0; cl < p_col(k); cl++) begin
          e.ch   = c;
          e.row  = rw;
          e.col  = cl;
          e.addr = 16'(int'(b) + c * p_chs(k) + rw * p_rs(k) + cl);
          e.last = (c == p_ch(k) - 1) && (rw == p_row(k) - 1) && (cl == p_col(k) - 1);
          q.push_back(e);
        end
    @(negedge clk);
    chk_idle(k, "pre");
    st[k]  = 1;
    bs[k]  = b;
    rdy[k] = 0;
    @(negedge clk);
    st[k]  = 0;
    while (idx < q.size() && cyc < 2000) begin
      e = q[idx];
      chk("valid", 32'(ov[k]), 1);
      chk("busy",  32'(obusy[k]), 1);
      chk("done_early", 32'(odone[k]), 0);
      chk("ch",   32'(och[k]),  32'(e.ch));
      chk("row",  32'(orow[k]), 32'(e.row));
      chk("col",  32'(ocol[k]), 32'(e.col));
      chk("addr", 32'(oaddr[k]), 32'(e.addr));
      chk("last", 32'(olast[k]), 32'(e.last));
      if (idx == rst_at) begin
        rdy[k] = 1;
        rst = 1;
        #1;
        chk_idle(k, "rst");
        chk("rst_ch",   32'(och[k]), 0);
        chk("rst_col",  32'(ocol[k]), 0);
        chk("rst_addr", 32'(oaddr[k]), 0);
        chk("rst_last", 32'(olast[k]), 0);
        @(negedge clk);
        rst = 0;
        rdy[k] = 0;
        @(negedge clk);
        chk_idle(k, "post_rst");
        @(negedge clk);
        chk_idle(k, "post_rst2");
        return;
      end
      case (mode)
        0:       r = 1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      st[k]  = (idx == restart_at);
      bs[k]  = 16'h0200;
      rdy[k] = r;
      @(negedge clk);
      cyc++;
      if (r) idx++;
    end
    st[k]  = 0;
    rdy[k] = 0;
    if (cyc >= 2000) chk("timeout", 1, 0);
    chk("done_pulse", 32'(odone[k]), 1);
    chk("done_valid", 32'(ov[k]), 0);
    chk("done_busy",  32'(obusy[k]), 1);
    st[k] = start_on_done;
    bs[k] = 16'h0300;
    @(negedge clk);
    st[k] = 0;
    chk_idle(k, "after_done");
    @(negedge clk);
    chk_idle(k, "after_done2");
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      st[k] = 0; bs[k] = '0; rdy[k] = 0;
    end
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_idle(k, "reset");
      chk("reset_addr", 32'(oaddr[k]), 0);
      chk("reset_col",  32'(ocol[k]), 0);
      chk("reset_last", 32'(olast[k]), 0);
    end
    rst = 0;

    walk(0, 16'h0100, 0, -1, -1, 0);   // basic walk
    walk(0, 16'h0100, 1, -1, -1, 0);   // backpressure 1,0,0
    walk(0, 16'h0100, 0, 5, -1, 1);    // start while busy and on done
    walk(1, 16'hFFFF, 0, -1, -1, 0);   // degenerate tile
    walk(1, 16'h0000, 0, -1, -1, 0);
    walk(2, 16'hFFFE, 0, -1, -1, 0);   // address wrap
    walk(0, 16'h0100, 0, -1, 2, 0);    // reset mid-walk
    walk(0, 16'h0100, 0, -1, -1, 0);   // restart from (0,0,0)
    for (int i = 0; i < 4; i++) begin
      walk(0, 16'($urandom), 2, -1, -1, 0);
      walk(2, 16'($urandom), 2, -1, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
